kp_colscan: RTL and testbench
=============================

Name: kp_colscan

Overview:
Keypad column driver and key-event generator; the drive side of the kpc/kpr keypad interface.
- Walks a single active-low column across kpc and synchronizes the raw row lines.
- The combinational keypad decoder turns kpc plus the synchronized rows into kphit/num; this block consumes that result.
- It freezes the scan on a hit, debounces press and release, and emits one clean key event per press to keypad control.

Parameters:
SCAN_DIV, 1000, clock cycles each column is held low while scanning (>=2)
DEBOUNCE_CNT, 50000, consecutive stable cycles required to accept a press or a release (>=2)
REPEAT_DLY, 25000000, cycles from accepted press to first auto-repeat (used only with KP_AUTOREPEAT_EN)
REPEAT_RATE, 5000000, cycles between subsequent auto-repeats (used only with KP_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock; the block uses one clock
reset  in  1  reset, asynchronous and active-high
kpr  in  4  raw keypad rows, active-low, asynchronous to clk
kpc  out  4  column drive, exactly one bit low, registered
kpr_sync  out  4  kpr after a 2-flop synchronizer; feeds the decoder
kphit  in  1  decoder hit, combinational from kpc and kpr_sync
num  in  4  decoder key code, valid while kphit=1
key_valid  out  1  one-cycle pulse per accepted key event
key_code  out  4  code of last accepted key, registered, stable between events
key_held  out  1  high while a debounced key is down

Behaviour:
- Reset values (async, immediate): kpc=4'b0111, kpr_sync=4'hF (both sync flops set to 1), key_valid=0, key_code=4'hF, key_held=0, state=SCAN, all counters=0.
- Synchronizer: kpr reaches kpr_sync 2 clk edges after a change.
- SCAN state:
  - kpc rotates 0111->1011->1101->1110->0111. Each column is held SCAN_DIV cycles via a divider counting 0..SCAN_DIV-1.
  - If kphit=1 in any cycle: next state is DEBOUNCE, kpc frozen, num captured into cap_code, debounce counter cleared. The hit takes priority over a rotation due in the same cycle.
- DEBOUNCE state:
  - Each cycle with kphit=1 and num==cap_code, the counter increments.
  - If kphit=0 or num!=cap_code: return to SCAN. kpc is kept, the divider restarts at 0, and no event is produced.
  - When the counter reaches DEBOUNCE_CNT-1 with a stable hit: go to PRESSED. In the first PRESSED cycle, key_valid=1 for exactly one cycle, key_code=cap_code, key_held=1.
  - Press latency: key_valid is high DEBOUNCE_CNT cycles after DEBOUNCE is entered.
- PRESSED state:
  - kpc stays frozen.
  - When kphit=0: go to RELEASE and clear the counter.
  - A num change while kphit=1 is ignored; a second key in the same column produces no event.
- RELEASE state:
  - Each cycle with kphit=0, the counter increments.
  - If kphit=1: return to PRESSED. No new key_valid, counter cleared.
  - When the counter reaches DEBOUNCE_CNT-1: go to SCAN, key_held=0, divider cleared, and rotation resumes from the frozen column.
- key_code is never modified outside an accepted event.
- Keys in other columns are invisible while the scan is frozen. This is by design.
- Reset asserted mid-operation: all state returns to reset values on the same edge, with no key_valid pulse. After reset releases, the scan restarts at 0111.
- Counters are sized $clog2 of their largest parameter and never wrap. Each is compared against its parameter minus 1 and cleared on every state entry.

Optional Feature:
KP_AUTOREPEAT_EN
- Defined:
  - In PRESSED, a repeat counter runs from entry.
  - At REPEAT_DLY cycles, key_valid pulses 1 cycle with the same key_code.
  - Further pulses follow every REPEAT_RATE cycles while PRESSED.
  - The counter clears on leaving PRESSED. A RELEASE->PRESSED bounce restarts the REPEAT_DLY wait.
- Undefined: exactly one key_valid per press; repeat logic and the REPEAT_* parameters are unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DLY=40, REPEAT_RATE=16; bench keypad model drives kpr row low when its key's column is low, plus a real decoder):
- Reset, no key -> kpc=0111 after reset, steps to 1011, 1101, 1110, 0111 every 4 clks; key_valid never asserts; key_code=4'hF.
- Hold key '5' (column 1011, row 1011) -> scan freezes at 1011; exactly one key_valid pulse 8 clks after DEBOUNCE entry; key_code=4'h5, key_held=1. Release -> key_held=0 8 clks after kphit drops; scan resumes at 1011.
- Key '9' bounces, pressed 3 clks then open 2 clks, repeated 4 times, then stable -> no event during bouncing; a single key_valid with key_code=4'h9 after the stable press.
- Key 'A' held, then release glitches open 3 clks, closed 1 clk, then open stable -> one key_valid total; key_held stays 1 through the glitch.
- Assert reset while in PRESSED with key_code=4'h5 -> kpc=0111, key_held=0, key_code=4'hF immediately (async); no key_valid pulse.
- With KP_AUTOREPEAT_EN, hold '0' for 100 clks after the event -> key_valid at +0, +40, +56, +72, +88; all with key_code=4'h0. Without the macro -> only the +0 pulse.

Source files
------------

// File: rtl/kp_colscan.sv
// kp_colscan: keypad column scanner with row synchronizer and press/release debounce.
// Define KP_AUTOREPEAT_EN to add timed auto-repeat of the held key.
module kp_colscan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] kpr_sync,
  input  logic       kphit,
  input  logic [3:0] num,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);
  logic [1:0]    state;
  logic [3:0]    sync1, cap_code;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic          stable, rep_due;
  assign stable = kphit && num == cap_code;
`ifdef KP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE);
  localparam logic [RW-1:0] DLY_MAX  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rcnt;
  logic          rep;
  assign rep_due = rep ? rcnt == RATE_MAX : rcnt == DLY_MAX;
  // rep marks that the first (longer) delay has elapsed; later periods use the rate
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (state != PRESSED || !kphit) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (rep_due) begin
      rcnt <= '0;
      rep  <= 1'b1;
    end else
      rcnt <= rcnt + 1'b1;
`else
  assign rep_due = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= SCAN;
      sync1     <= 4'hF;
      kpr_sync  <= 4'hF;
      kpc       <= 4'b0111;
      div       <= '0;
      cnt       <= '0;
      cap_code  <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'hF;
      key_held  <= 1'b0;
    end else begin
      sync1     <= kpr;
      kpr_sync  <= sync1;
      key_valid <= 1'b0;
      case (state)
        SCAN:
          if (kphit) begin
            state    <= DEBOUNCE;
            cap_code <= num;
            cnt      <= '0;
            div      <= '0;
          end else if (div == DIV_MAX) begin
            div <= '0;
            kpc <= {kpc[0], kpc[3:1]};
          end else
            div <= div + 1'b1;
        DEBOUNCE:
          if (!stable) begin
            state <= SCAN;
            div   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_valid <= 1'b1;
            key_code  <= cap_code;
            key_held  <= 1'b1;
          end else
            cnt <= cnt + 1'b1;
        PRESSED:
          if (!kphit) begin
            state <= RELEASE;
            cnt   <= '0;
          end else if (rep_due)
            key_valid <= 1'b1;
        default:
          if (kphit) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state    <= SCAN;
            cnt      <= '0;
            div      <= '0;
            key_held <= 1'b0;
          end else
            cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_kp_colscan.sv
// tb_kp_colscan: keypad model + decoder around kp_colscan, cycle-checked against a behavioural model.
module tb_kp_colscan;
  localparam int SD = 4, DB = 8, RD = 40, RR = 16;
`ifdef KP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] kpr, kpc, kpr_sync, num, key_code;
  logic kphit, key_valid, key_held;
  logic [15:0] down = '0;
  int errors = 0, checks = 0, pulses = 0;

  kp_colscan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DLY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .kpr(kpr), .kpc(kpc), .kpr_sync(kpr_sync),
    .kphit(kphit), .num(num), .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // keypad layout, row-major: position p sits at row p/4, column p%4
  function automatic logic [3:0] key_at(int p);
    logic [63:0] t;
    t = 64'h123A_456B_789C_E0FD;
    return t[63-4*p -: 4];
  endfunction
  function automatic int pos_of(logic [3:0] k);
    for (int p = 0; p < 16; p++) if (key_at(p) == k) return p;
    return 0;
  endfunction
  function automatic logic [3:0] rows_of(logic [3:0] cols, logic [15:0] d);
    logic [3:0] r;
    r = 4'hF;
    for (int p = 0; p < 16; p++) if (d[p] && !cols[3-p%4]) r[3-p/4] = 1'b0;
    return r;
  endfunction
  function automatic logic [4:0] decode(logic [3:0] cols, logic [3:0] rows);
    for (int p = 0; p < 16; p++) if (!cols[3-p%4] && !rows[3-p/4]) return {1'b1, key_at(p)};
    return 5'h0;
  endfunction
  function automatic logic [3:0] col_drive(int c);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> c);
  endfunction

  always_comb kpr = rows_of(kpc, down);
  always_comb {kphit, num} = decode(kpc, kpr_sync);

  // behavioural model: column index, run lengths of stable/quiet cycles, age in the held state
  int m_col, m_tick, m_run, m_quiet, m_age;
  bit m_frozen, m_held, m_valid;
  logic [3:0] m_s1, m_s2, m_cap, m_code;

  task automatic model_reset();
    m_col = 0; m_tick = 0; m_run = 0; m_quiet = 0; m_age = 0;
    m_frozen = 0; m_held = 0; m_valid = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_cap = 4'h0; m_code = 4'hF;
  endtask

  task automatic model_step();
    logic [4:0] d;
    logic [3:0] mk;
    mk = col_drive(m_col);
    d = decode(mk, m_s2);
    m_s2 = m_s1;
    m_s1 = rows_of(mk, down);
    m_valid = 0;
    if (!m_frozen) begin
      if (d[4]) begin
        m_frozen = 1; m_cap = d[3:0]; m_run = 0;
      end else begin
        m_tick++;
        if (m_tick == SD) begin m_tick = 0; m_col = (m_col + 1) % 4; end
      end
    end else if (!m_held) begin
      if (d[4] && d[3:0] == m_cap) begin
        m_run++;
        if (m_run == DB) begin m_held = 1; m_quiet = 0; m_age = 0; m_valid = 1; m_code = m_cap; end
      end else begin
        m_frozen = 0; m_tick = 0;
      end
    end else if (m_quiet == 0) begin
      if (d[4]) begin
        m_age++;
        if (AR && m_age >= RD && (m_age - RD) % RR == 0) m_valid = 1;
      end else m_quiet = 1;
    end else if (d[4]) begin
      m_quiet = 0; m_age = 0;
    end else begin
      m_quiet++;
      if (m_quiet == DB + 1) begin m_held = 0; m_frozen = 0; m_tick = 0; end
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulses++;
    check("model", int'({kpc, kpr_sync, key_valid, key_code, key_held}),
          int'({col_drive(m_col), m_s2, m_valid, m_code, m_held}));
  endtask

  typedef struct {
    logic [3:0] key;
    bit         press;
    int         cyc;
    int         pulses;
    bit         held;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic [3:0] k, bit p, int c, int n, bit h, logic [3:0] code);
    vec_t v;
    v.key = k; v.press = p; v.cyc = c; v.pulses = n; v.held = h; v.code = code;
    tbl.push_back(v);
  endfunction

  initial begin
    int rel[$];
    int idx;
    for (int i = 0; i < 4; i++) begin add(4'h9, 1, 3, 0, 0, 4'hF); add(4'h9, 0, 2, 0, 0, 4'hF); end
    add(4'h9, 1, 45, 1, 1, 4'h9);
    add(4'h9, 0, 30, 0, 0, 4'h9);
    add(4'hA, 1, 45, 1, 1, 4'hA);
    add(4'hA, 0, 3, 0, 1, 4'hA);
    add(4'hA, 1, 1, 0, 1, 4'hA);
    add(4'hA, 0, 30, 0, 0, 4'hA);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vals", int'({kpc, kpr_sync, key_valid, key_code, key_held}), int'({4'b0111, 4'hF, 1'b0, 4'hF, 1'b0}));
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("scan_kpc", int'(kpc), int'(col_drive((i / 4) % 4)));
    end
    check("scan_no_valid", pulses, 0);
    down[pos_of(4'h5)] = 1'b1;
    repeat (14) step();
    check("k5_pre", int'({kpc, key_valid, key_held}), int'({4'b1011, 1'b0, 1'b0}));
    step();
    check("k5_event", int'({key_valid, key_code, key_held}), int'({1'b1, 4'h5, 1'b1}));
    step();
    check("k5_one_pulse", int'({key_valid, key_held}), int'({1'b0, 1'b1}));
    repeat (2) step();
    down = '0;
    repeat (10) step();
    check("k5_held_during_release", int'(key_held), 1);
    step();
    check("k5_released", int'(key_held), 0);
    repeat (3) step();
    check("resume_same_col", int'(kpc), int'(4'b1011));
    step();
    check("resume_next_col", int'(kpc), int'(4'b1101));
    down[pos_of(4'h5)] = 1'b1;
    for (int i = 0; i < 60 && key_held !== 1'b1; i++) step();
    check("press_timeout", int'(key_held), 1);
    repeat (3) step();
    pulses = 0;
    #2 reset = 1'b1;
    #1;
    check("async_reset", int'({kpc, kpr_sync, key_valid, key_code, key_held}), int'({4'b0111, 4'hF, 1'b0, 4'hF, 1'b0}));
    down = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_no_valid", int'(key_valid), 0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      down = tbl[i].press ? 16'(1) << pos_of(tbl[i].key) : 16'h0;
      pulses = 0;
      repeat (tbl[i].cyc) step();
      check($sformatf("vec%0d_pulses", i), pulses, tbl[i].pulses);
      check($sformatf("vec%0d_held", i), int'(key_held), int'(tbl[i].held));
      check($sformatf("vec%0d_code", i), int'(key_code), int'(tbl[i].code));
    end
    down = 16'(1) << pos_of(4'h0);
    pulses = 0;
    for (int i = 0; i < 60 && pulses == 0; i++) step();
    check("rep_first", int'({pulses[3:0], key_code}), int'({4'd1, 4'h0}));
    for (int k = 1; k <= 100; k++) begin
      step();
      if (key_valid === 1'b1) begin
        rel.push_back(k);
        check("rep_code", int'(key_code), 0);
      end
    end
    check("rep_count", rel.size(), AR ? 4 : 0);
    foreach (rel[i]) check("rep_at", rel[i], RD + RR * i);
    down = '0;
    repeat (30) step();
    for (int n = 0; n < 30; n++) begin
      down = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, 15));
        down[idx] = 1'b1;
      end
      repeat ($urandom_range(1, 50)) step();
      down = '0;
      repeat ($urandom_range(1, 40)) step();
    end
    repeat (30) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
